// File: rtl/mnist_pkg.sv
// Shared types and display constants for the MNIST classification output stage.
// The seven-segment table maps a class index to an active-low {dp,g,f,e,d,c,b,a} code.
package mnist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  localparam int DEF_NUM_CLASSES = 10;

  localparam logic [7:0] HEX_BLANK = 8'hFF;
  localparam logic [7:0] HEX_ERR   = 8'h86;

  // Digits 0..9; anything larger shows "E". The decimal point stays dark.
  function automatic logic [7:0] seg7_code(input int unsigned idx);
    logic [7:0] code;
    case (idx)
      0:       code = 8'hC0;
      1:       code = 8'hF9;
      2:       code = 8'hA4;
      3:       code = 8'hB0;
      4:       code = 8'h99;
      5:       code = 8'h92;
      6:       code = 8'h82;
      7:       code = 8'hF8;
      8:       code = 8'h80;
      9:       code = 8'h90;
      default: code = HEX_ERR;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/hex7_decoder.sv
// Combinational class index to active-low seven-segment code.
module hex7_decoder
  import mnist_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       code
);

  always_comb begin
    code = seg7_code(32'(idx));
  end

endmodule

// File: rtl/mnist_argmax_unit.sv
// Streaming argmax over one frame of signed class scores; publishes the winning
// index, score, one-hot LED vector and HEX0 code, holding them until the next frame.
module mnist_argmax_unit
  import mnist_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int IDX_W       = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         score_valid,
  input  logic signed [DATA_WIDTH-1:0] score_data,
  output logic                         score_ready,
  output logic                         busy,
  output logic                         result_valid,
  output logic [IDX_W-1:0]             result_idx,
  output logic [DATA_WIDTH-1:0]        result_score,
  output logic [NUM_CLASSES-1:0]       classes,
  output logic [7:0]                   hex_out
);

  localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [IDX_W-1:0]             LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t                         state_reg;
  logic [IDX_W-1:0]               cnt_reg;
  logic [IDX_W-1:0]               max_idx_reg;
  logic signed [DATA_WIDTH-1:0]   max_reg;

  logic                           result_valid_reg;
  logic [IDX_W-1:0]               result_idx_reg;
  logic [DATA_WIDTH-1:0]          result_score_reg;
  logic [NUM_CLASSES-1:0]         classes_reg;
  logic [7:0]                     hex_reg;

  logic                           in_collect;
  logic                           beat;
  logic                           take;
  logic                           last_beat;
  logic signed [DATA_WIDTH-1:0]   max_next;
  logic [IDX_W-1:0]               max_idx_next;
  logic [NUM_CLASSES-1:0]         classes_next;
  logic [7:0]                     hex_next;

  assign in_collect = (state_reg == COLLECT);
  assign score_ready = in_collect;
  assign busy        = in_collect;

  // A start in the same cycle as a beat wins: that beat belongs to the aborted frame.
  assign beat      = in_collect && score_valid && !start;
  // Strict compare keeps the lowest index on ties.
  assign take      = (cnt_reg == '0) || (score_data > max_reg);
  assign last_beat = beat && (cnt_reg == LAST_IDX);

  assign max_next     = take ? score_data : max_reg;
  assign max_idx_next = take ? cnt_reg : max_idx_reg;

  // Results are computed from the post-beat maximum so they are visible during DONE.
  hex7_decoder #(
    .IDX_W(IDX_W)
  ) u_hex7_decoder (
    .idx  (max_idx_next),
    .code (hex_next)
  );

  generate
    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_onehot
      assign classes_next[gi] = (max_idx_next == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      max_reg          <= MOST_NEG;
      max_idx_reg      <= '0;
      result_valid_reg <= 1'b0;
      result_idx_reg   <= '0;
      result_score_reg <= '0;
      classes_reg      <= '0;
      hex_reg          <= HEX_BLANK;
    end else begin
      result_valid_reg <= 1'b0;
      if (start) begin
        state_reg   <= COLLECT;
        cnt_reg     <= '0;
        max_reg     <= MOST_NEG;
        max_idx_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg <= IDLE;
          end
          COLLECT: begin
            if (beat) begin
              cnt_reg     <= cnt_reg + 1'b1;
              max_reg     <= max_next;
              max_idx_reg <= max_idx_next;
            end
            if (last_beat) begin
              state_reg        <= DONE;
              result_valid_reg <= 1'b1;
              result_idx_reg   <= max_idx_next;
              result_score_reg <= max_next;
              classes_reg      <= classes_next;
              hex_reg          <= hex_next;
            end
          end
          DONE: begin
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign result_valid = result_valid_reg;
  assign result_idx   = result_idx_reg;
  assign result_score = result_score_reg;
  assign classes      = classes_reg;
  assign hex_out      = hex_reg;

endmodule

// File: tb/tb_mnist_argmax_unit.sv
// Directed bench for mnist_argmax_unit: hand-computed frames, gaps, abort and reset.
module tb_mnist_argmax_unit;

  localparam int DW = 16;
  localparam int NC = 10;
  localparam int IW = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 score_valid;
  logic signed [DW-1:0] score_data;
  logic                 score_ready;
  logic                 busy;
  logic                 result_valid;
  logic [IW-1:0]        result_idx;
  logic [DW-1:0]        result_score;
  logic [NC-1:0]        classes;
  logic [7:0]           hex_out;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;

  logic signed [DW-1:0] vec [NC];

  mnist_argmax_unit #(
    .DATA_WIDTH  (DW),
    .NUM_CLASSES (NC),
    .IDX_W       (IW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .score_valid  (score_valid),
    .score_data   (score_data),
    .score_ready  (score_ready),
    .busy         (busy),
    .result_valid (result_valid),
    .result_idx   (result_idx),
    .result_score (result_score),
    .classes      (classes),
    .hex_out      (hex_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (result_valid === 1'b1) pulse_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Caller is positioned at a negedge. Pulses start, streams vec[], then checks DONE.
  task automatic do_frame(input string name, input bit gaps, input logic [7:0] prev_hex,
                          input logic [IW-1:0] exp_idx, input logic [DW-1:0] exp_score,
                          input logic [NC-1:0] exp_cls, input logic [7:0] exp_hex);
    int p0;
    p0 = pulse_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({name, " ready_after_start"}, 32'(score_ready), 32'd1);
    check_eq({name, " hex_held"}, 32'(hex_out), 32'(prev_hex));
    for (int i = 0; i < NC; i++) begin
      if (gaps && (i % 3 == 1)) begin
        score_valid = 1'b0;
        @(negedge clk);
      end
      score_valid = 1'b1;
      score_data  = vec[i];
      @(negedge clk);
    end
    score_valid = 1'b0;
    check_eq({name, " result_valid"}, 32'(result_valid), 32'd1);
    check_eq({name, " result_idx"}, 32'(result_idx), 32'(exp_idx));
    check_eq({name, " result_score"}, 32'(result_score), 32'(exp_score));
    check_eq({name, " classes"}, 32'(classes), 32'(exp_cls));
    check_eq({name, " hex_out"}, 32'(hex_out), 32'(exp_hex));
    check_eq({name, " ready_in_done"}, 32'(score_ready), 32'd0);
    @(negedge clk);
    check_eq({name, " valid_drops"}, 32'(result_valid), 32'd0);
    check_eq({name, " busy_idle"}, 32'(busy), 32'd0);
    check_eq({name, " hex_holds"}, 32'(hex_out), 32'(exp_hex));
    check_eq({name, " one_pulse"}, 32'(pulse_cnt - p0), 32'd1);
  endtask

  initial begin
    int p0;
    reset       = 1'b1;
    start       = 1'b0;
    score_valid = 1'b0;
    score_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst hex_out", 32'(hex_out), 32'hFF);
    check_eq("rst classes", 32'(classes), 32'd0);
    check_eq("rst score_ready", 32'(score_ready), 32'd0);
    check_eq("rst result_valid", 32'(result_valid), 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst result_idx", 32'(result_idx), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    vec = '{16'sd5, -16'sd3, 16'sd12, 16'sd7, 16'sd0, 16'sd12, -16'sd100, 16'sd1, 16'sd2, 16'sd3};
    do_frame("f1", 1'b0, 8'hFF, 4'd2, 16'd12, 10'b0000000100, 8'hA4);

    vec = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
            16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
    do_frame("neg", 1'b0, 8'hA4, 4'd0, 16'h8000, 10'b0000000001, 8'hC0);

    vec = '{16'sd5, -16'sd3, 16'sd12, 16'sd7, 16'sd0, 16'sd12, -16'sd100, 16'sd1, 16'sd2, 16'sd3};
    do_frame("gap", 1'b1, 8'hC0, 4'd2, 16'd12, 10'b0000000100, 8'hA4);

    // Abort after 4 beats; the beat alongside the restart (1000) must be dropped.
    p0 = pulse_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      score_valid = 1'b1;
      score_data  = 16'sd200 + 16'(i);
      @(negedge clk);
    end
    score_data = 16'sd1000;
    check_eq("abort hex_held", 32'(hex_out), 32'hA4);
    check_eq("abort idx_held", 32'(result_idx), 32'd2);
    vec = '{16'sd0, 16'sd5, -16'sd7, 16'sd29, -16'sd30, 16'sd3, 16'sd10, 16'sd29, -16'sd1, 16'sd30};
    do_frame("restart", 1'b0, 8'hA4, 4'd9, 16'd30, 10'b1000000000, 8'h90);
    check_eq("abort no_extra_pulse", 32'(pulse_cnt - p0), 32'd1);

    // Mid-frame reset after 6 beats, then a fresh frame.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      score_valid = 1'b1;
      score_data  = 16'sd500;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst hex_out", 32'(hex_out), 32'hFF);
    check_eq("midrst classes", 32'(classes), 32'd0);
    check_eq("midrst busy", 32'(busy), 32'd0);
    reset       = 1'b0;
    score_valid = 1'b0;
    @(negedge clk);
    check_eq("midrst ready_idle", 32'(score_ready), 32'd0);
    vec = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd50, -16'sd5, 16'sd6, 16'sd7, 16'sd8, 16'sd9};
    do_frame("fresh", 1'b0, 8'hFF, 4'd4, 16'd50, 10'b0000010000, 8'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
